// File: rtl/cv32e40p_fetch_aligner.sv
// rtl/cv32e40p_fetch_aligner.sv - realigns prefetch words into whole RV32I/RV32IC instructions with PC
//
// Purpose:
//   Takes word-aligned 32-bit fetch words and presents complete instructions with their PC.
//   Handles 32-bit instructions that straddle a word boundary and compressed instructions in
//   either halfword.
//
// Configuration macro: CV32E40P_ALIGNER_RVC_EN
//   defined   - RV32IC realignment (ALIGNED / MISALIGNED / BRANCH_MIS)
//   undefined - RV32I pass-through, PC steps by 4, bits [1:0] of every address forced to 0
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fetch_valid_i/rdata_i prefetch word (word-aligned address)
//   fetch_ready_o         word consumed this cycle
//   instr_valid_o/ready_i instruction handshake
//   instr_rdata_o         instruction, compressed ones zero-extended in [31:16]
//   instr_is_compressed_o instr_rdata_o[1:0] != 2'b11
//   pc_o                  PC of instr_rdata_o
//   branch_i/addr_i       redirect, highest priority

module cv32e40p_fetch_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_is_compressed_o,
    output logic [31:0] pc_o,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);

`ifdef CV32E40P_ALIGNER_RVC_EN

    typedef enum logic [1:0] {
        ALIGNED    = 2'd0,
        MISALIGNED = 2'd1,
        BRANCH_MIS = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] resid_q, resid_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        resid_d       = resid_q;
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_rdata_o = fetch_rdata_i;

        if (rst) begin
            // Handshakes stay quiet while the flops are being reset.
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
        end else if (branch_i) begin
            // Drop whatever word is presented; it belongs to the old path.
            fetch_ready_o = 1'b1;
            pc_d          = branch_addr_i & ~32'h1;
            resid_d       = 16'h0;
            state_d       = branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
        end else begin
            case (state_q)
                ALIGNED: begin
                    if (fetch_valid_i) begin
                        instr_valid_o = 1'b1;
                        if (fetch_rdata_i[1:0] != 2'b11) begin
                            instr_rdata_o = {16'h0, fetch_rdata_i[15:0]};
                            if (instr_ready_i) begin
                                fetch_ready_o = 1'b1;
                                resid_d       = fetch_rdata_i[31:16];
                                pc_d          = pc_q + 32'd2;
                                state_d       = MISALIGNED;
                            end
                        end else begin
                            instr_rdata_o = fetch_rdata_i;
                            if (instr_ready_i) begin
                                fetch_ready_o = 1'b1;
                                pc_d          = pc_q + 32'd4;
                            end
                        end
                    end
                end
                MISALIGNED: begin
                    if (resid_q[1:0] != 2'b11) begin
                        // Residual compressed instruction needs no new word.
                        instr_valid_o = 1'b1;
                        instr_rdata_o = {16'h0, resid_q};
                        if (instr_ready_i) begin
                            pc_d    = pc_q + 32'd2;
                            state_d = ALIGNED;
                        end
                    end else if (fetch_valid_i) begin
                        instr_valid_o = 1'b1;
                        instr_rdata_o = {fetch_rdata_i[15:0], resid_q};
                        if (instr_ready_i) begin
                            fetch_ready_o = 1'b1;
                            resid_d       = fetch_rdata_i[31:16];
                            pc_d          = pc_q + 32'd4;
                        end
                    end
                end
                BRANCH_MIS: begin
                    if (fetch_valid_i) begin
                        if (fetch_rdata_i[17:16] != 2'b11) begin
                            instr_valid_o = 1'b1;
                            instr_rdata_o = {16'h0, fetch_rdata_i[31:16]};
                            if (instr_ready_i) begin
                                fetch_ready_o = 1'b1;
                                pc_d          = pc_q + 32'd2;
                                state_d       = ALIGNED;
                            end
                        end else begin
                            // First half of a straddling instruction: park it, pc unchanged.
                            fetch_ready_o = 1'b1;
                            resid_d       = fetch_rdata_i[31:16];
                            state_d       = MISALIGNED;
                        end
                    end
                end
                default: begin
                    state_d = ALIGNED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALIGNED;
            pc_q    <= BOOT_ADDR & ~32'h1;
            resid_q <= 16'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            resid_q <= resid_d;
        end
    end

    assign instr_is_compressed_o = (instr_rdata_o[1:0] != 2'b11);
    assign pc_o                  = pc_q;

`else

    logic [31:0] pc_q, pc_d;

    always_comb begin
        instr_rdata_o = fetch_rdata_i;
        instr_valid_o = fetch_valid_i & ~branch_i & ~rst;
        fetch_ready_o = ~rst & ((instr_valid_o & instr_ready_i) | branch_i);
        pc_d          = pc_q;
        if (branch_i) begin
            pc_d = branch_addr_i & ~32'h3;
        end else if (instr_valid_o && instr_ready_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= BOOT_ADDR & ~32'h3;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign instr_is_compressed_o = 1'b0;
    assign pc_o                  = pc_q;

`endif

endmodule

// File: tb/tb_cv32e40p_fetch_aligner.sv
// tb/tb_cv32e40p_fetch_aligner.sv - self-checking bench for cv32e40p_fetch_aligner

module tb_cv32e40p_fetch_aligner;

    localparam logic [31:0] BOOT = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid_i = 1'b0;
    logic [31:0] fetch_rdata_i = 32'h0;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic        instr_is_compressed_o;
    logic [31:0] pc_o;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40p_fetch_aligner #(.BOOT_ADDR(BOOT)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_rdata_i         (fetch_rdata_i),
        .fetch_ready_o         (fetch_ready_o),
        .instr_valid_o         (instr_valid_o),
        .instr_ready_i         (instr_ready_i),
        .instr_rdata_o         (instr_rdata_o),
        .instr_is_compressed_o (instr_is_compressed_o),
        .pc_o                  (pc_o),
        .branch_i              (branch_i),
        .branch_addr_i         (branch_addr_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a halfword stream. Pending halfwords (at most one buffered) are
    // concatenated with the halves of the presented word; an instruction is the first
    // halfword if compressed, otherwise the first two.
    logic [15:0] m_buf;
    bit          m_has  = 0;
    bit          m_skip = 0;
    logic [31:0] m_pc   = 32'h0;
    logic [15:0] mh [0:2];
    int          mn, mws, mlen, mlim, mstart;
    bit          mev, macc, mcons;
    logic [31:0] minstr;

    always @(negedge clk) begin
`ifdef CV32E40P_ALIGNER_RVC_EN
        if (rst) begin
            chk("m_rst_valid", {31'h0, instr_valid_o}, 32'h0);
            chk("m_rst_ready", {31'h0, fetch_ready_o}, 32'h0);
            m_pc   = BOOT & ~32'h1;
            m_has  = 0;
            m_skip = 0;
        end else if (branch_i) begin
            chk("m_br_valid", {31'h0, instr_valid_o}, 32'h0);
            chk("m_br_ready", {31'h0, fetch_ready_o}, 32'h1);
            m_pc   = branch_addr_i & ~32'h1;
            m_has  = 0;
            m_skip = branch_addr_i[1];
        end else begin
            mn = 0;
            if (m_has) begin
                mh[0] = m_buf;
                mn    = 1;
            end
            mws = mn;
            if (fetch_valid_i) begin
                if (!m_skip) begin
                    mh[mn] = fetch_rdata_i[15:0];
                    mn++;
                end
                mh[mn] = fetch_rdata_i[31:16];
                mn++;
            end
            mlen = 0;
            if (mn >= 1) begin
                if (mh[0][1:0] != 2'b11) mlen = 1;
                else if (mn >= 2)        mlen = 2;
            end
            mev   = (mlen > 0);
            macc  = mev && instr_ready_i;
            mcons = fetch_valid_i && ((macc && mlen > mws) || !mev);
            minstr = (mlen == 2) ? {mh[1], mh[0]} : {16'h0, mh[0]};
            chk("m_valid", {31'h0, instr_valid_o}, {31'h0, mev});
            chk("m_ready", {31'h0, fetch_ready_o}, {31'h0, mcons});
            if (mev) begin
                chk("m_instr", instr_rdata_o, minstr);
                chk("m_cmp", {31'h0, instr_is_compressed_o}, {31'h0, (mlen == 1)});
                chk("m_pc", pc_o, m_pc);
            end
            if (macc || mcons) begin
                mlim   = mcons ? mn : mws;
                mstart = macc ? mlen : 0;
                m_has  = 0;
                for (int i = mstart; i < mlim; i++) begin
                    m_buf = mh[i];
                    m_has = 1;
                end
                if (macc)  m_pc = m_pc + 32'(2 * mlen);
                if (mcons) m_skip = 0;
            end
        end
`else
        if (rst) begin
            chk("m_rst_valid", {31'h0, instr_valid_o}, 32'h0);
            chk("m_rst_ready", {31'h0, fetch_ready_o}, 32'h0);
            m_pc = BOOT & ~32'h3;
        end else begin
            mev = fetch_valid_i && !branch_i;
            chk("m_valid", {31'h0, instr_valid_o}, {31'h0, mev});
            chk("m_ready", {31'h0, fetch_ready_o}, {31'h0, (mev && instr_ready_i) || branch_i});
            if (mev) begin
                chk("m_instr", instr_rdata_o, fetch_rdata_i);
                chk("m_cmp", {31'h0, instr_is_compressed_o}, 32'h0);
                chk("m_pc", pc_o, m_pc);
            end
            if (branch_i)                  m_pc = branch_addr_i & ~32'h3;
            else if (mev && instr_ready_i) m_pc = m_pc + 32'd4;
        end
`endif
    end

    task automatic cyc(input logic r, input logic v, input logic [31:0] d,
                       input logic rdy, input logic br, input logic [31:0] ba);
        @(posedge clk);
        #1;
        rst           = r;
        fetch_valid_i = v;
        fetch_rdata_i = d;
        instr_ready_i = rdy;
        branch_i      = br;
        branch_addr_i = ba;
        @(negedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic r,
                              input logic [31:0] instr, input logic c, input logic [31:0] pc);
        chk({name, "_valid"}, {31'h0, instr_valid_o}, {31'h0, v});
        chk({name, "_ready"}, {31'h0, fetch_ready_o}, {31'h0, r});
        if (v) begin
            chk({name, "_instr"}, instr_rdata_o, instr);
            chk({name, "_cmp"}, {31'h0, instr_is_compressed_o}, {31'h0, c});
            chk({name, "_pc"}, pc_o, pc);
        end
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
        else if (h[1:0] == 2'b11)      h[1:0] = 2'b01;
        return h;
    endfunction

    logic [31:0] rba;

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        expect_out("reset", 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
`ifdef CV32E40P_ALIGNER_RVC_EN
        cyc(0, 1, 32'h0000_0013, 1, 0, 0);  expect_out("t1a", 1, 1, 32'h0000_0013, 0, 32'h80);
        cyc(0, 1, 32'h0000_0013, 1, 0, 0);  expect_out("t1b", 1, 1, 32'h0000_0013, 0, 32'h84);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h4501_4505, 1, 0, 0);  expect_out("t2a", 1, 1, 32'h0000_4505, 1, 32'h80);
        cyc(0, 0, 32'h0, 1, 0, 0);          expect_out("t2b", 1, 0, 32'h0000_4501, 1, 32'h82);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h0513_4505, 1, 0, 0);  expect_out("t3a", 1, 1, 32'h0000_4505, 1, 32'h80);
        cyc(0, 1, 32'h1234_0000, 1, 0, 0);  expect_out("t3b", 1, 1, 32'h0000_0513, 0, 32'h82);
        cyc(0, 0, 32'h0, 1, 0, 0);          expect_out("t3c", 1, 0, 32'h0000_1234, 1, 32'h86);
        cyc(0, 1, 32'hDEAD_BEEF, 1, 1, 32'h102); expect_out("t4br", 0, 1, 0, 0, 0);
        cyc(0, 1, 32'h0093_0001, 1, 0, 0);  expect_out("t4a", 0, 1, 0, 0, 0);
        cyc(0, 1, 32'hABCD_0000, 1, 0, 0);  expect_out("t4b", 1, 1, 32'h0000_0093, 0, 32'h102);
        cyc(0, 0, 32'h0, 0, 0, 0);          expect_out("t5hold", 1, 0, 32'h0000_ABCD, 1, 32'h106);
        cyc(0, 0, 32'h0, 1, 1, 32'h200);    expect_out("t5br", 0, 1, 0, 0, 0);
        cyc(0, 1, 32'h0000_0013, 1, 0, 0);  expect_out("t5a", 1, 1, 32'h0000_0013, 0, 32'h200);
        cyc(0, 1, 32'h4501_4505, 1, 0, 0);  expect_out("t6a", 1, 1, 32'h0000_4505, 1, 32'h204);
        cyc(1, 0, 32'h0, 1, 0, 0);          expect_out("t6rst", 0, 0, 0, 0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0);          expect_out("t6b", 0, 0, 0, 0, 0);
        chk("t6_pc", pc_o, 32'h80);
        cyc(0, 1, 32'h0000_0013, 1, 0, 0);  expect_out("t6c", 1, 1, 32'h0000_0013, 0, 32'h80);
        cyc(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFF); expect_out("wrbr", 0, 1, 0, 0, 0);
        cyc(0, 1, 32'h0001_0000, 1, 0, 0);  expect_out("wra", 1, 1, 32'h0000_0001, 1, 32'hFFFF_FFFE);
        cyc(0, 1, 32'h0000_0013, 1, 0, 0);  expect_out("wrb", 1, 1, 32'h0000_0013, 0, 32'h0);
        cyc(0, 1, 32'h4501_4505, 0, 0, 0);  expect_out("stall1", 1, 0, 32'h0000_4505, 1, 32'h4);
        cyc(0, 1, 32'h4501_4505, 0, 0, 0);  expect_out("stall2", 1, 0, 32'h0000_4505, 1, 32'h4);
`else
        cyc(0, 1, 32'h0000_0013, 1, 0, 0);  expect_out("t1a", 1, 1, 32'h0000_0013, 0, 32'h80);
        cyc(0, 1, 32'h0000_0013, 1, 0, 0);  expect_out("t1b", 1, 1, 32'h0000_0013, 0, 32'h84);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h4501_4505, 1, 0, 0);  expect_out("t2a", 1, 1, 32'h4501_4505, 0, 32'h80);
        cyc(0, 1, 32'h0000_0013, 0, 0, 0);  expect_out("stall", 1, 0, 32'h0000_0013, 0, 32'h84);
        cyc(0, 1, 32'h0000_0013, 1, 1, 32'h103); expect_out("br", 0, 1, 0, 0, 0);
        cyc(0, 1, 32'h0000_0013, 1, 0, 0);  expect_out("bra", 1, 1, 32'h0000_0013, 0, 32'h100);
        cyc(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFE); expect_out("wrbr", 0, 1, 0, 0, 0);
        cyc(0, 1, 32'h0000_0013, 1, 0, 0);  expect_out("wra", 1, 1, 32'h0000_0013, 0, 32'hFFFF_FFFC);
        cyc(0, 1, 32'h0000_0033, 1, 0, 0);  expect_out("wrb", 1, 1, 32'h0000_0033, 0, 32'h0);
        cyc(1, 0, 32'h0, 1, 0, 0);          expect_out("rst2", 0, 0, 0, 0, 0);
`endif
        for (int i = 0; i < 4000; i++) begin
            rba = $urandom;
            if ($urandom_range(3, 0) == 0) rba = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            cyc(($urandom_range(199, 0) == 0),
                ($urandom_range(3, 0) != 0),
                {rand_half(), rand_half()},
                ($urandom_range(3, 0) != 0),
                ($urandom_range(19, 0) == 0),
                rba);
        end
        cyc(0, 0, 32'h0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
